// File: rtl/mem_ctrl.sv
// mem_ctrl -- bus master in front of a 2^AW x DW asynchronous-read RAM.
//
// Turns a valid/ready request into RAM cycles: single-byte writes, and
// incrementing read bursts of 1..16 beats. Read beats and write
// acknowledges come back on a one-cycle rsp_valid strobe. This block is the
// only master-side driver of data_bus, and ram_we / ram_oe are never high
// in the same cycle.
//
// Ports
//   clk        clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  request accepted when high (IDLE only)
//   req_we     1 = write, 0 = read
//   req_addr   start address
//   req_wdata  write byte (ignored for reads)
//   req_len    read beats minus 1 (ignored for writes)
//   rsp_valid  one-cycle strobe per read beat / write ack
//   rsp_data   read byte, or the written byte on a write ack
//   rsp_last   with rsp_valid: final beat / write ack
//   busy       operation in progress
//   ram_addr   RAM address
//   ram_we     RAM write enable
//   ram_oe     RAM output enable
//   data_bus   shared tristate data bus to the RAM
module mem_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [3:0]    req_len,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic          ram_oe,
  inout  wire  [DW-1:0] data_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] wdata_p0;
  logic [3:0]    cnt_p0;
  logic          accept;

  // Burst addresses wrap modulo the RAM depth.
  function automatic logic [AW-1:0] incr_addr(input logic [AW-1:0] a);
    return a + {{(AW-1){1'b0}}, 1'b1};
  endfunction

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid & req_ready;

  // Strobes decode straight from state so an asynchronous reset releases
  // the bus and drops we/oe in the same instant.
  assign ram_oe   = (state == S_RD);
  assign ram_we   = (state == S_WR);
  assign ram_addr = addr_p0;
  assign data_bus = (state == S_WR) ? wdata_p0 : {DW{1'bz}};

  // Request stage: sequencing and address/beat bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_p0 <= '0;
      cnt_p0  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_p0 <= req_addr;
            cnt_p0  <= req_len;
            state   <= req_we ? S_WR : S_RD;
          end
        end
        S_RD: begin
          addr_p0 <= incr_addr(addr_p0);
          cnt_p0  <= cnt_p0 - 4'd1;
          if (cnt_p0 == 4'd0) state <= S_IDLE;
        end
        S_WR:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write data is only consumed while in WR, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) wdata_p0 <= req_wdata;
  end

  // Response stage: one cycle behind the RAM cycle that produced it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      if (state == S_RD) begin
        rsp_valid <= 1'b1;
        rsp_last  <= (cnt_p0 == 4'd0);
        rsp_data  <= data_bus;
      end else if (state == S_WR) begin
        rsp_valid <= 1'b1;
        rsp_last  <= 1'b1;
        rsp_data  <= wdata_p0;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl -- directed self-checking bench for mem_ctrl, with a
// behavioural 256-byte asynchronous-read RAM on the shared data bus.
module tb_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic [3:0] req_len = 4'd0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       busy;
  logic [7:0] ram_addr;
  logic       ram_we;
  logic       ram_oe;
  wire  [7:0] data_bus;

  logic       tb_drv_en = 1'b0;
  logic [7:0] tb_drv_val = 8'h00;
  logic [7:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  mem_ctrl #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe),
    .data_bus(data_bus)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read onto the bus, write at posedge.
  assign data_bus = ram_oe ? mem[ram_addr] : 8'hzz;
  // Probe driver used to show the bus is released by the controller.
  assign data_bus = tb_drv_en ? tb_drv_val : 8'hzz;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= data_bus;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: issue one write from an IDLE cycle, return in its ack cycle.
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h44; req_wdata = 8'h99;
    step(); step();
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", req_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (ram_we !== 1'b0 || ram_oe !== 1'b0) begin n_err++; $display("FAIL rst_we_oe got %b%b want 00", ram_we, ram_oe); end
    n_vec++; if (rsp_valid !== 1'b0 || rsp_last !== 1'b0) begin n_err++; $display("FAIL rst_rsp got %b%b want 00", rsp_valid, rsp_last); end
    n_vec++; if (rsp_data !== 8'h00) begin n_err++; $display("FAIL rst_rsp_data got %h want 00", rsp_data); end
    n_vec++; if (ram_addr !== 8'h00) begin n_err++; $display("FAIL rst_ram_addr got %h want 00", ram_addr); end
    req_valid = 1'b0;
    rst_n = 1'b1;
    step();
    n_vec++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release busy/ready got %b%b want 01", busy, req_ready); end
    tb_drv_en = 1'b1; tb_drv_val = 8'h5A;
    #1;
    n_vec++; if (data_bus !== 8'h5A) begin n_err++; $display("FAIL idle_bus_released got %h want 5a", data_bus); end
    tb_drv_en = 1'b0;
  endtask

  task automatic test_write();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'hA5;
    step();
    req_valid = 1'b0; req_wdata = 8'h00;
    n_vec++; if (ram_we !== 1'b1 || ram_oe !== 1'b0) begin n_err++; $display("FAIL wr_we_oe got %b%b want 10", ram_we, ram_oe); end
    n_vec++; if (ram_addr !== 8'h10) begin n_err++; $display("FAIL wr_addr got %h want 10", ram_addr); end
    n_vec++; if (data_bus !== 8'hA5) begin n_err++; $display("FAIL wr_bus got %h want a5", data_bus); end
    n_vec++; if (req_ready !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL wr_busy ready/busy got %b%b want 01", req_ready, busy); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_early_rsp got %b want 0", rsp_valid); end
    step();
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL wr_one_cycle got %b want 0", ram_we); end
    n_vec++; if (rsp_valid !== 1'b1 || rsp_last !== 1'b1) begin n_err++; $display("FAIL wr_ack valid/last got %b%b want 11", rsp_valid, rsp_last); end
    n_vec++; if (rsp_data !== 8'hA5) begin n_err++; $display("FAIL wr_ack_data got %h want a5", rsp_data); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL wr_ack_ready got %b want 1", req_ready); end
    step();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wr_ack_single got %b want 0", rsp_valid); end
  endtask

  task automatic test_burst();
    logic [7:0] exp_d [5];
    exp_d[0] = 8'hA5; exp_d[1] = 8'h01; exp_d[2] = 8'h02; exp_d[3] = 8'h03; exp_d[4] = 8'h04;
    for (int i = 1; i <= 4; i++) do_write(8'h10 + 8'(i), 8'(i));
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_len = 4'd4;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (ram_oe !== 1'b1 || ram_we !== 1'b0) begin n_err++; $display("FAIL burst_oe[%0d] oe/we got %b%b want 10", i, ram_oe, ram_we); end
      n_vec++; if (ram_addr !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL burst_addr[%0d] got %h want %h", i, ram_addr, 8'h10 + 8'(i)); end
      step();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d[i]) begin n_err++; $display("FAIL burst_beat[%0d] valid/data got %b/%h want 1/%h", i, rsp_valid, rsp_data, exp_d[i]); end
      n_vec++; if (rsp_last !== (i == 4)) begin n_err++; $display("FAIL burst_last[%0d] got %b want %b", i, rsp_last, (i == 4)); end
    end
    n_vec++; if (ram_oe !== 1'b0) begin n_err++; $display("FAIL burst_oe_end got %b want 0", ram_oe); end
    step();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL burst_extra_beat got %b want 0", rsp_valid); end
  endtask

  task automatic test_wrap();
    do_write(8'hFF, 8'h7E);
    do_write(8'h00, 8'h81);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFF; req_len = 4'd1;
    step();
    req_valid = 1'b0;
    n_vec++; if (ram_addr !== 8'hFF) begin n_err++; $display("FAIL wrap_addr0 got %h want ff", ram_addr); end
    step();
    n_vec++; if (ram_addr !== 8'h00 || ram_oe !== 1'b1) begin n_err++; $display("FAIL wrap_addr1 addr/oe got %h/%b want 00/1", ram_addr, ram_oe); end
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h7E || rsp_last !== 1'b0) begin n_err++; $display("FAIL wrap_beat0 got %b/%h/%b want 1/7e/0", rsp_valid, rsp_data, rsp_last); end
    step();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h81 || rsp_last !== 1'b1) begin n_err++; $display("FAIL wrap_beat1 got %b/%h/%b want 1/81/1", rsp_valid, rsp_data, rsp_last); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) do_write(8'h30 + 8'(i), 8'h40 + 8'(i));
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h30; req_len = 4'd15;
    step();
    // Keep a competing write request pending with a wandering address.
    req_we = 1'b1; req_wdata = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      req_addr = 8'h80 + 8'(i); req_len = 4'(i);
      #1;
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d] got %b want 0", i, req_ready); end
      n_vec++; if (ram_addr !== 8'h30 + 8'(i) || ram_oe !== 1'b1) begin n_err++; $display("FAIL hold_addr[%0d] addr/oe got %h/%b want %h/1", i, ram_addr, ram_oe, 8'h30 + 8'(i)); end
      step();
      n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h40 + 8'(i) || rsp_last !== (i == 15)) begin n_err++; $display("FAIL hold_beat[%0d] got %b/%h/%b want 1/%h/%b", i, rsp_valid, rsp_data, rsp_last, 8'h40 + 8'(i), (i == 15)); end
    end
    req_addr = 8'h50;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_last got %b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    n_vec++; if (ram_we !== 1'b1 || ram_addr !== 8'h50 || data_bus !== 8'hC3) begin n_err++; $display("FAIL b2b_write we/addr/bus got %b/%h/%h want 1/50/c3", ram_we, ram_addr, data_bus); end
    step();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hC3) begin n_err++; $display("FAIL b2b_ack got %b/%h want 1/c3", rsp_valid, rsp_data); end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h30; req_len = 4'd15;
    step();
    req_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    n_vec++; if (ram_oe !== 1'b0 || ram_we !== 1'b0) begin n_err++; $display("FAIL midrst_oe got %b%b want 00", ram_oe, ram_we); end
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_valid/busy got %b%b want 00", rsp_valid, busy); end
    req_valid = 1'b1;
    step();
    n_vec++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_ignore busy/valid got %b%b want 00", busy, rsp_valid); end
    req_valid = 1'b0;
    rst_n = 1'b1;
    step();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_len = 4'd0;
    step();
    req_valid = 1'b0;
    step();
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5 || rsp_last !== 1'b1) begin n_err++; $display("FAIL midrst_readback got %b/%h/%b want 1/a5/1", rsp_valid, rsp_data, rsp_last); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
